// File: rtl/shift_pkg.sv
// Shared encodings for the shift command sequencer: register pin codes,
// command opcodes, FSM state type and default widths.
package shift_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    localparam logic [1:0] DIR_SHL  = 2'b00;
    localparam logic [1:0] DIR_SHR  = 2'b10;
    localparam logic [1:0] DIR_LOAD = 2'b11;
    localparam logic [1:0] DIR_SET7 = 2'b01;

    localparam logic [1:0] OP_SHL  = 2'd0;
    localparam logic [1:0] OP_SHR  = 2'd1;
    localparam logic [1:0] OP_LOAD = 2'd2;
    localparam logic [1:0] OP_SET7 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic [1:0] op_to_dir(input logic [1:0] op);
        case (op)
            OP_SHL:  return DIR_SHL;
            OP_SHR:  return DIR_SHR;
            OP_LOAD: return DIR_LOAD;
            default: return DIR_SET7;
        endcase
    endfunction

endpackage

// File: rtl/shift_step_cnt.sv
// Loadable step down-counter; load values above WIDTH are clamped to WIDTH
// because more shifts than register bits cannot change the result.
module shift_step_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             last
);

    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(WIDTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= (32'(load_val) > 32'(WIDTH)) ? SAT_VAL : load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/shift_cmd_seq.sv
// Command sequencer driving the shift register pins: one command per
// valid/ready handshake, then per-cycle enables and a done pulse.
module shift_cmd_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             sr_enable,
    output logic [1:0]       sr_dir,
    output logic [WIDTH-1:0] sr_data,
    output logic [1:0]       fsm_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both 1; the requester holds the command until then.
    state_t           state;
    logic             hs;
    logic             shift_op;
    logic             zero_steps;
    logic [CNT_W-1:0] load_val;
    logic [WIDTH-1:0] pin_data;
    logic [CNT_W-1:0] remaining;
    logic             cnt_zero;
    logic             cnt_last;

    assign cmd_ready  = (state == IDLE);
    assign fsm_state  = state;
    assign hs         = cmd_valid & cmd_ready;
    assign shift_op   = (cmd_op == OP_SHL) || (cmd_op == OP_SHR);
    assign zero_steps = shift_op && (cmd_count == '0);
    assign load_val   = shift_op ? cmd_count : CNT_W'(1);

    always_comb begin
        pin_data = '0;
        case (cmd_op)
            OP_LOAD: pin_data = cmd_data;
            OP_SET7: pin_data = {{(WIDTH-1){1'b0}}, cmd_data[0]};
            default: pin_data = '0;
        endcase
    end

    shift_step_cnt #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_step_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (hs),
        .dec      ((state == RUN) && !flush),
        .load_val (load_val),
        .count    (remaining),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sr_enable <= 1'b0;
            sr_dir    <= DIR_SHL;
            sr_data   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        sr_dir  <= op_to_dir(cmd_op);
                        sr_data <= pin_data;
                        busy    <= 1'b1;
                        if (zero_steps) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            sr_enable <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Flush only stops further steps; already-issued shifts stay.
                    if (flush) begin
                        state     <= IDLE;
                        sr_enable <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cnt_last || cnt_zero) begin
                        state     <= FIN;
                        sr_enable <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    sr_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Self-checking bench for shift_cmd_seq with a model of the downstream
// 8-bit shift register driven from the sequencer pins.
module tb_shift_cmd_seq;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [CW-1:0] cmd_count = '0;
    logic [W-1:0]  cmd_data = '0;
    logic          flush = 1'b0;
    logic          busy;
    logic          done;
    logic          sr_enable;
    logic [1:0]    sr_dir;
    logic [W-1:0]  sr_data;
    logic [1:0]    fsm_state;

    logic [W-1:0]  reg_m;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  cur_v = '0;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    shift_cmd_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .sr_enable (sr_enable),
        .sr_dir    (sr_dir),
        .sr_data   (sr_data),
        .fsm_state (fsm_state)
    );

    // Downstream shift register, cleared by the same reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) reg_m <= '0;
        else if (sr_enable) begin
            case (sr_dir)
                2'b00: reg_m <= {reg_m[W-2:0], 1'b0};
                2'b10: reg_m <= {1'b0, reg_m[W-1:1]};
                2'b11: reg_m <= sr_data;
                default: reg_m <= {sr_data[0], reg_m[W-2:0]};
            endcase
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int steps_of(input logic [1:0] op, input logic [CW-1:0] cnt);
        if (op == 2'd0 || op == 2'd1) return (int'(cnt) > W) ? W : int'(cnt);
        return 1;
    endfunction

    function automatic logic [1:0] dir_of(input logic [1:0] op);
        case (op)
            2'd0: return 2'b00;
            2'd1: return 2'b10;
            2'd2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [W-1:0] data_of(input logic [1:0] op, input logic [W-1:0] d);
        if (op == 2'd2) return d;
        if (op == 2'd3) return {{(W-1){1'b0}}, d[0]};
        return '0;
    endfunction

    function automatic logic [W-1:0] apply(input logic [W-1:0] v, input logic [1:0] op,
                                           input int steps, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < steps; i++) begin
            case (op)
                2'd0: r = r << 1;
                2'd1: r = r >> 1;
                2'd2: r = d;
                default: r[W-1] = d[0];
            endcase
        end
        return r;
    endfunction

    task automatic drive_cmd(input logic [1:0] op, input logic [CW-1:0] cnt,
                             input logic [W-1:0] d, input logic hs_flush, output bit ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check_val("ready_timeout", 32'(cmd_ready), 32'd1);
            ok = 1'b0;
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = d;
        flush     = hs_flush;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        flush     = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_count = CW'($urandom_range(0, 15));
        cmd_data  = W'($urandom_range(0, 255));
        ok = 1'b1;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] cnt,
                           input logic [W-1:0] d, input logic hs_flush);
        int steps, en_cnt, done_at, bad_ctl;
        bit ok;
        logic [W-1:0] exp_v;
        steps = steps_of(op, cnt);
        exp_v = apply(cur_v, op, steps, d);
        exp_q.push_back(exp_v);
        cur_v = exp_v;
        drive_cmd(op, cnt, d, hs_flush, ok);
        if (!ok) begin
            void'(exp_q.pop_back());
            return;
        end
        en_cnt = 0;
        done_at = 0;
        bad_ctl = 0;
        for (int k = 1; k <= W + 4; k++) begin
            @(negedge clk);
            if (sr_enable) begin
                en_cnt++;
                if (sr_dir !== dir_of(op) || sr_data !== data_of(op, d)) bad_ctl++;
            end
            if (cmd_ready || !busy) bad_ctl++;
            if (done) begin
                done_at = k;
                break;
            end
        end
        check_val("enable_count", 32'(en_cnt), 32'(steps));
        check_val("done_cycle", 32'(done_at), 32'(steps + 1));
        check_val("pins_during_cmd", 32'(bad_ctl), 32'd0);
        check_val("reg_value", 32'(reg_m), 32'(exp_q.pop_front()));
        @(negedge clk);
        check_val("idle_after_done", {29'd0, done, cmd_ready, busy}, 32'b010);
    endtask

    task automatic run_flush_test();
        int en_cnt, done_seen;
        bit ok;
        logic [W-1:0] exp_v;
        exp_v = apply(cur_v, 2'd0, 3, '0);
        exp_q.push_back(exp_v);
        cur_v = exp_v;
        drive_cmd(2'd0, CW'(6), '0, 1'b0, ok);
        if (!ok) begin
            void'(exp_q.pop_back());
            return;
        end
        en_cnt = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (sr_enable) en_cnt++;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_val("flush_enable_count", 32'(en_cnt), 32'd3);
        check_val("flush_outputs", {28'd0, sr_enable, done, busy, cmd_ready}, 32'b0001);
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || sr_enable) done_seen++;
        end
        check_val("flush_no_done", 32'(done_seen), 32'd0);
        check_val("flush_reg", 32'(reg_m), 32'(exp_q.pop_front()));
        check_val("flush_reg_const", 32'(reg_m), 32'h08);
    endtask

    task automatic run_reset_test();
        bit ok;
        exp_q.push_back('0);
        cur_v = '0;
        drive_cmd(2'd1, CW'(5), '0, 1'b0, ok);
        if (!ok) begin
            void'(exp_q.pop_back());
            return;
        end
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_rst_ctl", {28'd0, sr_enable, busy, done, cmd_ready}, 32'b0001);
        check_val("async_rst_pins", {22'd0, sr_dir, sr_data}, 32'd0);
        check_val("async_rst_state", 32'(fsm_state), 32'd0);
        check_val("async_rst_reg", 32'(reg_m), 32'(exp_q.pop_front()));
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("in_reset", {27'd0, cmd_ready, busy, done, sr_enable, fsm_state == 2'd0},
                  32'b10001);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_ctl", {28'd0, cmd_ready, busy, done, sr_enable}, 32'b1000);
        check_val("idle_data", {22'd0, sr_dir, sr_data}, 32'd0);
        check_val("idle_reg", 32'(reg_m), 32'd0);

        run_cmd(2'd2, CW'(0), 8'hA5, 1'b0);
        run_cmd(2'd0, CW'(3), 8'h00, 1'b0);
        check_val("load_shl_const", 32'(reg_m), 32'h28);

        run_cmd(2'd2, CW'(0), 8'hFF, 1'b0);
        run_cmd(2'd1, CW'(12), 8'h00, 1'b0);
        check_val("shr_sat_const", 32'(reg_m), 32'h00);

        run_cmd(2'd0, CW'(0), 8'h5A, 1'b0);
        run_cmd(2'd2, CW'(0), 8'h00, 1'b0);
        run_cmd(2'd3, CW'(0), 8'hFF, 1'b0);
        check_val("set7_const", 32'(reg_m), 32'h80);

        run_cmd(2'd2, CW'(0), 8'h01, 1'b0);
        run_flush_test();

        run_cmd(2'd2, CW'(0), 8'h81, 1'b1);
        run_cmd(2'd1, CW'(15), 8'h00, 1'b0);

        run_reset_test();
        run_cmd(2'd2, CW'(0), 8'h3C, 1'b0);
        check_val("after_reset_load", 32'(reg_m), 32'h3C);

        for (int i = 0; i < 12; i++) begin
            run_cmd(2'($urandom_range(0, 3)), CW'($urandom_range(0, 15)),
                    W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
